dla_walker_engine: RTL and testbench

- Diffusion-limited-aggregation pixel producer. It feeds the SRAM framebuffer that the VGA scan-out path reads.
- Runs one random walker at a time over an X_MAX x Y_MAX grid. Before each step it reads the walker's own pixel and its 4-neighbours through a single-outstanding memory request port.
- When a walker touches the aggregate it writes FILL at its position, then spawns the next walker.
- The downstream SRAM arbiter interleaves these requests with VGA reads.

---
 rtl/dla_walker_engine_if.sv | 21 ++
 rtl/dla_walker_engine.sv | 199 +++++++++++++++++++
 tb/tb_dla_walker_engine.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dla_walker_engine_if.sv
// Memory request port of the DLA walker: one outstanding read or write,
// held stable until granted; read data returns on rvalid.
interface dla_walker_engine_if;
  logic        oReq;
  logic        oWE;
  logic [19:0] oAddr;
  logic [15:0] oWData;
  logic        iGnt;
  logic        iRValid;
  logic [15:0] iRData;

  modport master (
    output oReq, oWE, oAddr, oWData,
    input  iGnt, iRValid, iRData
  );

  modport slave (
    input  oReq, oWE, oAddr, oWData,
    output iGnt, iRValid, iRData
  );
endinterface

// File: rtl/dla_walker_engine.sv
// Diffusion-limited-aggregation pixel producer: one random walker at a time,
// probing self and 4-neighbours through a single-outstanding memory port.
module dla_walker_engine #(
  parameter int          X_MAX       = 640,
  parameter int          Y_MAX       = 480,
  parameter int          SEED_X      = 320,
  parameter int          SEED_Y      = 240,
  parameter int          MAX_WALKERS = 1000,
  parameter int          MAX_STEPS   = 65535,
  parameter logic [15:0] FILL        = 16'hFFFF
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iStart,
  dla_walker_engine_if.master        mem,
  output logic                       oBusy,
  output logic                       oDone,
  output logic [13:0]                oCount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_SPAWN = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_MOVE  = 3'd5;
  localparam logic [2:0] S_STICK = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [2:0] I_SELF = 3'd0;
  localparam logic [2:0] I_W    = 3'd1;
  localparam logic [2:0] I_E    = 3'd2;
  localparam logic [2:0] I_N    = 3'd3;
  localparam logic [2:0] I_S    = 3'd4;

  localparam logic [9:0]  X_LAST   = 10'(X_MAX - 1);
  localparam logic [9:0]  Y_LAST   = 10'(Y_MAX - 1);
  localparam logic [19:0] SEED_A   = {10'(SEED_X), 10'(SEED_Y)};
  localparam logic [15:0] STEP_LIM = 16'(MAX_STEPS);
  localparam logic [13:0] WALK_LIM = 14'(MAX_WALKERS);

  localparam logic [30:0] LFSR_X_INIT = 31'h1;
  localparam logic [30:0] LFSR_Y_INIT = 31'h5A5A5A5;

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [15:0] steps;
  logic [30:0] lfsr_x;
  logic [30:0] lfsr_y;
  logic        req;
  logic        we;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic [13:0] count;

  function automatic logic [30:0] lfsr_next(input logic [30:0] l);
    return {l[29:0], l[30] ^ l[27]};
  endfunction

  logic rx;
  logic ry;
  assign rx = lfsr_x[0];
  assign ry = lfsr_y[0];

  // Probe target for the current neighbour index; off-grid probes are skipped.
  logic [9:0] px;
  logic [9:0] py;
  logic       off;
  always_comb begin
    px  = x;
    py  = y;
    off = 1'b0;
    case (idx)
      I_W: begin px = x - 10'd1; off = (x == 10'd0);   end
      I_E: begin px = x + 10'd1; off = (x == X_LAST);  end
      I_N: begin py = y - 10'd1; off = (y == 10'd0);   end
      I_S: begin py = y + 10'd1; off = (y == Y_LAST);  end
      default: ;
    endcase
  end

  logic [9:0]  mx;
  logic [9:0]  my;
  logic        mv_out;
  logic [13:0] count_nx;
  assign mx       = rx ? x + 10'd1 : x - 10'd1;
  assign my       = ry ? y + 10'd1 : y - 10'd1;
  assign mv_out   = (rx ? (x == X_LAST) : (x == 10'd0)) |
                    (ry ? (y == Y_LAST) : (y == 10'd0));
  assign count_nx = count + 14'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= S_IDLE;
      idx    <= I_SELF;
      x      <= 10'd0;
      y      <= 10'd0;
      steps  <= 16'd0;
      lfsr_x <= LFSR_X_INIT;
      lfsr_y <= LFSR_Y_INIT;
      req    <= 1'b0;
      we     <= 1'b0;
      addr   <= 20'd0;
      wdata  <= 16'd0;
      count  <= 14'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            count <= 14'd0;
            state <= S_SEED;
          end
        end
        S_SEED: begin
          if (!req) begin
            req   <= 1'b1;
            we    <= 1'b1;
            addr  <= SEED_A;
            wdata <= FILL;
          end else if (mem.iGnt) begin
            req   <= 1'b0;
            state <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          x      <= rx ? 10'd0 : X_LAST;
          y      <= ry ? 10'd0 : Y_LAST;
          steps  <= 16'd0;
          idx    <= I_SELF;
          lfsr_x <= lfsr_next(lfsr_x);
          lfsr_y <= lfsr_next(lfsr_y);
          state  <= S_RD;
        end
        S_RD: begin
          if (off) begin
            if (idx == I_S) state <= S_MOVE;
            else            idx   <= idx + 3'd1;
          end else if (!req) begin
            req  <= 1'b1;
            we   <= 1'b0;
            addr <= {px, py};
          end else if (mem.iGnt) begin
            req   <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.iRValid) begin
            if (mem.iRData != 16'd0) begin
              state <= (idx == I_SELF) ? S_SPAWN : S_STICK;
            end else if (idx == I_S) begin
              state <= S_MOVE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_RD;
            end
          end
        end
        S_MOVE: begin
          lfsr_x <= lfsr_next(lfsr_x);
          lfsr_y <= lfsr_next(lfsr_y);
          if (steps == STEP_LIM || mv_out) begin
            state <= S_SPAWN;
          end else begin
            x     <= mx;
            y     <= my;
            steps <= steps + 16'd1;
            idx   <= I_SELF;
            state <= S_RD;
          end
        end
        S_STICK: begin
          if (!req) begin
            req   <= 1'b1;
            we    <= 1'b1;
            addr  <= {x, y};
            wdata <= FILL;
          end else if (mem.iGnt) begin
            req   <= 1'b0;
            count <= count_nx;
            state <= (count_nx == WALK_LIM) ? S_DONE : S_SPAWN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem.oReq   = req;
  assign mem.oWE    = we;
  assign mem.oAddr  = addr;
  assign mem.oWData = wdata;
  assign oBusy      = (state != S_IDLE) && (state != S_DONE);
  assign oDone      = (state == S_DONE);
  assign oCount     = count;

endmodule

// File: tb/tb_dla_walker_engine.sv
// Bench for dla_walker_engine: a transaction-level DLA model predicts every
// memory request; a randomized responder grants, returns data and injects noise.
module tb_dla_walker_engine;
  localparam int XM = 8;
  localparam int YM = 6;
  localparam int SX = 4;
  localparam int SY = 3;
  localparam int MW = 2;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [13:0] count;

  always #5 clk = ~clk;

  dla_walker_engine_if mem ();

  dla_walker_engine #(
    .X_MAX(XM), .Y_MAX(YM), .SEED_X(SX), .SEED_Y(SY),
    .MAX_WALKERS(MW), .MAX_STEPS(MS), .FILL(16'hFFFF)
  ) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .mem(mem),
    .oBusy(busy), .oDone(done), .oCount(count)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [30:0] mlx;
  logic [30:0] mly;
  bit          filled [XM][YM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit take_x();
    bit b = mlx[0];
    mlx = {mlx[29:0], mlx[30] ^ mlx[27]};
    return b;
  endfunction

  function automatic bit take_y();
    bit b = mly[0];
    mly = {mly[29:0], mly[30] ^ mly[27]};
    return b;
  endfunction

  function automatic void push(input bit we, input int px, input int py, input logic [15:0] rd);
    txn_t t;
    t.we    = we;
    t.addr  = {10'(px), 10'(py)};
    t.wdata = we ? 16'hFFFF : 16'h0000;
    t.rdata = rd;
    exp_q.push_back(t);
  endfunction

  function automatic logic [15:0] pix(input bit v);
    return v ? 16'($urandom_range(1, 65535)) : 16'h0000;
  endfunction

  // Plays a whole run at the level of "walkers on a grid"; hot makes every
  // in-grid neighbour look occupied.
  task automatic model_run(input bit hot, output bit ok);
    int dx[4] = '{-1, 1, 0, 0};
    int dy[4] = '{0, 0, -1, 1};
    int stuck = 0;
    int spawns = 0;
    int x, y, nx, ny, steps;
    bit hit, v, bx, by;
    ok = 1'b1;
    foreach (filled[i, j]) filled[i][j] = 1'b0;
    filled[SX][SY] = 1'b1;
    push(1'b1, SX, SY, 16'h0);
    while (stuck < MW) begin
      if (spawns == 3000) begin ok = 1'b0; return; end
      spawns++;
      x = take_x() ? 0 : XM - 1;
      y = take_y() ? 0 : YM - 1;
      steps = 0;
      forever begin
        push(1'b0, x, y, pix(filled[x][y]));
        if (filled[x][y]) break;
        hit = 1'b0;
        for (int d = 0; d < 4 && !hit; d++) begin
          nx = x + dx[d];
          ny = y + dy[d];
          if (nx < 0 || nx >= XM || ny < 0 || ny >= YM) continue;
          v = hot || filled[nx][ny];
          push(1'b0, nx, ny, pix(v));
          hit = v;
        end
        if (hit) begin
          push(1'b1, x, y, 16'h0);
          filled[x][y] = 1'b1;
          stuck++;
          break;
        end
        bx = take_x();
        by = take_y();
        nx = bx ? x + 1 : x - 1;
        ny = by ? y + 1 : y - 1;
        if (steps == MS || nx < 0 || nx >= XM || ny < 0 || ny >= YM) break;
        x = nx;
        y = ny;
        steps++;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    mem.iGnt = 1'b0; mem.iRValid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("count_cleared", 32'(count), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Memory responder; returns once DONE is seen, or right after granting
  // read number abort_rd (abort_rd > 0).
  task automatic serve(input int budget, input int abort_rd, input bit stall, output bit fin);
    int pend = -1;
    int rd_cnt = 0;
    int hold = 0;
    bit stalled = 1'b0;
    bit gnt;
    logic [15:0] pdat = 16'h0;
    txn_t t;
    fin = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      mem.iGnt = 1'b0; mem.iRValid = 1'b0; mem.iRData = 16'($urandom); start = 1'b0;
      if (done) begin fin = 1'b1; return; end
      if (pend == 0) begin
        mem.iRValid = 1'b1; mem.iRData = pdat; pend = -1;
      end else if (pend > 0) begin
        pend--;
      end else if (hold > 0 || $urandom_range(0, 5) == 0) begin
        mem.iRValid = 1'b1; mem.iRData = 16'hFFFF;
      end
      if (busy && $urandom_range(0, 19) == 0) start = 1'b1;
      if (hold > 0) chk("stall_req_held", 32'(mem.oReq), 32'd1);
      if (mem.oReq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("req_we", 32'(mem.oWE), 32'(exp_q[0].we));
          chk("req_addr", 32'(mem.oAddr), 32'(exp_q[0].addr));
          if (exp_q[0].we) chk("req_wdata", 32'(mem.oWData), 32'(exp_q[0].wdata));
        end
        if (stall && !stalled && !mem.oWE) begin stalled = 1'b1; hold = 10; end
        gnt = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (hold > 0) hold--;
        mem.iGnt = gnt;
        if (gnt && exp_q.size() > 0) begin
          t = exp_q.pop_front();
          if (!t.we) begin
            pend = $urandom_range(0, 2);
            pdat = t.rdata;
            rd_cnt++;
            if (rd_cnt == abort_rd) return;
          end
        end
      end
    end
  endtask

  task automatic end_checks(input bit fin);
    chk("run_finished", 32'(fin), 32'd1);
    chk("done_flag", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("count_final", 32'(count), 32'(MW));
    chk("req_in_done", 32'(mem.oReq), 32'd0);
    chk("txn_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic model_or_die(input bit hot);
    bit ok;
    model_run(hot, ok);
    if (!ok) begin
      $display("FAIL model_run no convergence");
      $fatal(1, "model did not converge");
    end
  endtask

  initial begin
    bit fin;
    int nrd;
    rst = 1'b1; start = 1'b0;
    mem.iGnt = 1'b0; mem.iRValid = 1'b0; mem.iRData = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", 32'(mem.oReq), 32'd0);
    chk("rst_we", 32'(mem.oWE), 32'd0);
    chk("rst_addr", 32'(mem.oAddr), 32'd0);
    chk("rst_wdata", 32'(mem.oWData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    mlx = 31'h1;
    mly = 31'h5A5A5A5;

    // Run 1 with a 10-cycle grant stall on the first read.
    model_or_die(1'b0);
    do_start();
    serve(15000, 0, 1'b1, fin);
    end_checks(fin);

    // Re-run from DONE; LFSRs continue where they left off.
    model_or_die(1'b0);
    do_start();
    serve(15000, 0, 1'b0, fin);
    end_checks(fin);

    // Every neighbour occupied: each walker sticks on its first probe.
    model_or_die(1'b1);
    do_start();
    serve(15000, 0, 1'b0, fin);
    end_checks(fin);

    // Reset while waiting on the final neighbour read of the run.
    model_or_die(1'b0);
    nrd = 0;
    foreach (exp_q[i]) if (!exp_q[i].we) nrd++;
    do_start();
    serve(15000, nrd, 1'b0, fin);
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'(MW - 1));
    rst = 1'b1; mem.iGnt = 1'b0; mem.iRValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", 32'(mem.oReq), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    mem.iRValid = 1'b1; mem.iRData = 16'hFFFF;
    @(negedge clk);
    mem.iRValid = 1'b0;
    chk("late_rvalid_busy", 32'(busy), 32'd0);
    chk("late_rvalid_req", 32'(mem.oReq), 32'd0);
    chk("late_rvalid_done", 32'(done), 32'd0);

    // Fresh run after reset: LFSRs are back at their seeds.
    exp_q.delete();
    mlx = 31'h1;
    mly = 31'h5A5A5A5;
    model_or_die(1'b0);
    do_start();
    serve(15000, 0, 1'b0, fin);
    end_checks(fin);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
